// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer: queues command bytes, sends them to the port, and waits for ACK/0xFA.
// Optional resend support is enabled with `define PS2_HOST_RESEND_EN.
module ps2_host_ctrl #(
  parameter int unsigned CMDQ_DEPTH      = 4,
  parameter int unsigned RXQ_DEPTH       = 8,
  parameter int unsigned RESP_TIMEOUT_US = 20000,
  parameter int unsigned MAX_RETRY       = 2
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic [7:0] cmd_i,
  input  logic       cmd_wr_i,
  output logic       cmd_full_o,
  output logic [7:0] rx_data_o,
  input  logic       rx_rd_i,
  output logic       rx_empty_o,
  output logic       rx_ovf_o,
  input  logic       ovf_clr_i,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] port_cmd_o,
  output logic       port_cmd_v_o,
  input  logic       port_busy_i,
  input  logic       port_acked_i,
  input  logic       port_errd_i,
  input  logic [7:0] port_code_i,
  input  logic       port_code_v_i
);

  localparam int unsigned CAW = $clog2(CMDQ_DEPTH);
  localparam int unsigned RAW = $clog2(RXQ_DEPTH);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StGap      = 3'd2;
  localparam logic [2:0] StWaitTx   = 3'd3;
  localparam logic [2:0] StWaitResp = 3'd4;

  localparam logic [14:0] TimeoutLd = 15'(RESP_TIMEOUT_US);
  localparam logic [7:0]  CodeAck    = 8'hFA;
  localparam logic [7:0]  CodeResend = 8'hFE;

  // Command FIFO
  logic [7:0]   cmd_mem [CMDQ_DEPTH];
  logic [CAW:0] cmd_wp_q, cmd_rp_q;
  logic         cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic [7:0]   cmd_head;

  assign cmd_empty  = (cmd_wp_q == cmd_rp_q);
  assign cmd_full   = (cmd_wp_q[CAW] != cmd_rp_q[CAW]) &&
                      (cmd_wp_q[CAW-1:0] == cmd_rp_q[CAW-1:0]);
  assign cmd_push   = cmd_wr_i && (!cmd_full || cmd_pop);
  assign cmd_head   = cmd_mem[cmd_rp_q[CAW-1:0]];
  assign cmd_full_o = cmd_full;

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      cmd_wp_q <= '0;
      cmd_rp_q <= '0;
    end else begin
      if (cmd_push) cmd_wp_q <= cmd_wp_q + (CAW+1)'(1);
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + (CAW+1)'(1);
    end
  end

  always_ff @(posedge clk6x) begin
    if (cmd_push) cmd_mem[cmd_wp_q[CAW-1:0]] <= cmd_i;
  end

  // RX FIFO
  logic [7:0]   rx_mem [RXQ_DEPTH];
  logic [RAW:0] rx_wp_q, rx_rp_q;
  logic         rx_empty, rx_full, rx_push_req, rx_push, rx_pop, ovf_set;

  assign rx_empty    = (rx_wp_q == rx_rp_q);
  assign rx_full     = (rx_wp_q[RAW] != rx_rp_q[RAW]) &&
                       (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
  assign rx_pop      = rx_rd_i && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign ovf_set     = rx_push_req && rx_full && !rx_pop;
  assign rx_data_o   = rx_mem[rx_rp_q[RAW-1:0]];
  assign rx_empty_o  = rx_empty;

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_ovf_o <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + (RAW+1)'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + (RAW+1)'(1);
      // Set takes priority over clear.
      rx_ovf_o <= (rx_ovf_o && !ovf_clr_i) || ovf_set;
    end
  end

  always_ff @(posedge clk6x) begin
    if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= port_code_i;
  end

  // Sequencer
  logic [2:0]  state_q, state_d;
  logic [14:0] timer_q, timer_d;
  logic [7:0]  port_cmd_d;
  logic        port_cmd_v_d, done_d, err_d;
  logic        resend, fail, expired;

`ifdef PS2_HOST_RESEND_EN
  localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);
  logic [1:0] retry_q, retry_d;

  always_ff @(posedge clk6x) begin
    if (!resetn) retry_q <= 2'd0;
    else         retry_q <= retry_d;
  end
`endif

  assign expired = (timer_q == 15'd0);

  // Bytes that are not the response to the active command go to the RX FIFO.
  assign rx_push_req = port_code_v_i &&
                       !((state_q == StWaitResp) &&
                         ((port_code_i == CodeAck) || (port_code_i == CodeResend)));

  always_comb begin
    state_d      = state_q;
    timer_d      = (ck1us && !expired) ? timer_q - 15'd1 : timer_q;
    port_cmd_d   = port_cmd_o;
    port_cmd_v_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cmd_pop      = 1'b0;
    resend       = 1'b0;
    fail         = 1'b0;
`ifdef PS2_HOST_RESEND_EN
    retry_d      = retry_q;
`endif
    case (state_q)
      StIdle: begin
        if (!cmd_empty) begin
          state_d = StIssue;
`ifdef PS2_HOST_RESEND_EN
          retry_d = 2'd0;
`endif
        end
      end
      StIssue: begin
        if (!port_busy_i) begin
          port_cmd_d   = cmd_head;
          port_cmd_v_d = 1'b1;
          state_d      = StGap;
        end
      end
      StGap: begin
        timer_d = TimeoutLd;
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (port_acked_i) begin
          timer_d = TimeoutLd;
          state_d = StWaitResp;
        end else if (port_errd_i) begin
          resend = 1'b1;
        end else if (expired) begin
          fail = 1'b1;
        end
      end
      StWaitResp: begin
        if (port_code_v_i && (port_code_i == CodeAck)) begin
          done_d  = 1'b1;
          cmd_pop = 1'b1;
          state_d = StIdle;
        end else if (port_code_v_i && (port_code_i == CodeResend)) begin
          resend = 1'b1;
        end else if (!port_code_v_i && expired) begin
          fail = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (resend) begin
`ifdef PS2_HOST_RESEND_EN
      if (retry_q < MaxRetry) begin
        retry_d = retry_q + 2'd1;
        state_d = StIssue;
      end else begin
        fail = 1'b1;
      end
`else
      fail = 1'b1;
`endif
    end

    if (fail) begin
      err_d   = 1'b1;
      cmd_pop = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q      <= StIdle;
      timer_q      <= 15'd0;
      port_cmd_o   <= 8'd0;
      port_cmd_v_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      port_cmd_o   <= port_cmd_d;
      port_cmd_v_o <= port_cmd_v_d;
      done_o       <= done_d;
      err_o        <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed self-checking bench for ps2_host_ctrl; expectations follow PS2_HOST_RESEND_EN if defined.
module tb_ps2_host_ctrl;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       ck1us = 1'b0;
  logic [7:0] cmd_i = 8'd0;
  logic       cmd_wr_i = 1'b0;
  logic       cmd_full_o;
  logic [7:0] rx_data_o;
  logic       rx_rd_i = 1'b0;
  logic       rx_empty_o;
  logic       rx_ovf_o;
  logic       ovf_clr_i = 1'b0;
  logic       done_o;
  logic       err_o;
  logic [7:0] port_cmd_o;
  logic       port_cmd_v_o;
  logic       port_busy_i = 1'b0;
  logic       port_acked_i = 1'b0;
  logic       port_errd_i = 1'b0;
  logic [7:0] port_code_i = 8'd0;
  logic       port_code_v_i = 1'b0;

  always #5 clk6x = ~clk6x;

  ps2_host_ctrl dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .ck1us        (ck1us),
    .cmd_i        (cmd_i),
    .cmd_wr_i     (cmd_wr_i),
    .cmd_full_o   (cmd_full_o),
    .rx_data_o    (rx_data_o),
    .rx_rd_i      (rx_rd_i),
    .rx_empty_o   (rx_empty_o),
    .rx_ovf_o     (rx_ovf_o),
    .ovf_clr_i    (ovf_clr_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .port_cmd_o   (port_cmd_o),
    .port_cmd_v_o (port_cmd_v_o),
    .port_busy_i  (port_busy_i),
    .port_acked_i (port_acked_i),
    .port_errd_i  (port_errd_i),
    .port_code_i  (port_code_i),
    .port_code_v_i(port_code_v_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_send = 0;
  int n_done = 0;
  int n_err = 0;
  logic [7:0] last_cmd = 8'd0;
  int s_send, s_done, s_err;

  // Pulse monitor: each registered 1-cycle pulse is seen at exactly one edge.
  always @(posedge clk6x) begin
    if (port_cmd_v_o) begin
      n_send   <= n_send + 1;
      last_cmd <= port_cmd_o;
    end
    if (done_o) n_done <= n_done + 1;
    if (err_o)  n_err  <= n_err + 1;
  end

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_send = n_send;
    s_done = n_done;
    s_err  = n_err;
  endtask

  task automatic push(input logic [7:0] b);
    cmd_i = b;
    cmd_wr_i = 1'b1;
    tick();
    cmd_wr_i = 1'b0;
  endtask

  task automatic pulse_ack();
    port_acked_i = 1'b1;
    tick();
    port_acked_i = 1'b0;
  endtask

  task automatic send_code(input logic [7:0] b);
    port_code_i = b;
    port_code_v_i = 1'b1;
    tick();
    port_code_v_i = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd_i = 1'b1;
    tick();
    rx_rd_i = 1'b0;
  endtask

  // sel: 0 sends, 1 done pulses, 2 err pulses; an expired bound is a failed comparison.
  task automatic wait_for(input int sel, input int target, input int bound, input string tag);
    int cur;
    for (int i = 0; i < bound; i++) begin
      cur = (sel == 0) ? n_send : (sel == 1) ? n_done : n_err;
      if (cur >= target) break;
      tick();
    end
    cur = (sel == 0) ? n_send : (sel == 1) ? n_done : n_err;
    check(tag, 32'(cur >= target), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_cmd_full", 32'(cmd_full_o), 32'd0);
    check("rst_rx_empty", 32'(rx_empty_o), 32'd1);
    check("rst_ovf", 32'(rx_ovf_o), 32'd0);
    check("rst_outs", {20'd0, port_cmd_o, port_cmd_v_o, done_o, err_o, 1'b0}, 32'd0);
    resetn = 1'b1;
    tick();

    // Basic command 0xED
    snap();
    push(8'hED);
    wait_for(0, s_send + 1, 20, "basic_send");
    check("basic_byte", 32'(last_cmd), 32'hED);
    pulse_ack();
    send_code(8'hFA);
    wait_for(1, s_done + 1, 20, "basic_done");
    repeat (10) tick();
    check("basic_nsend", 32'(n_send - s_send), 32'd1);
    check("basic_ndone", 32'(n_done - s_done), 32'd1);
    check("basic_nerr", 32'(n_err - s_err), 32'd0);
    check("basic_rx_empty", 32'(rx_empty_o), 32'd1);

`ifdef PS2_HOST_RESEND_EN
    // Resend twice then ack
    snap();
    push(8'hF4);
    for (int r = 0; r < 3; r++) begin
      wait_for(0, s_send + r + 1, 20, "resend_send");
      pulse_ack();
      send_code((r < 2) ? 8'hFE : 8'hFA);
    end
    wait_for(1, s_done + 1, 20, "resend_done");
    repeat (10) tick();
    check("resend_nsend", 32'(n_send - s_send), 32'd3);
    check("resend_byte", 32'(last_cmd), 32'hF4);
    check("resend_nerr", 32'(n_err - s_err), 32'd0);

    // Resends exhausted
    snap();
    push(8'hF5);
    for (int r = 0; r < 3; r++) begin
      wait_for(0, s_send + r + 1, 20, "exh_send");
      pulse_ack();
      send_code(8'hFE);
    end
    wait_for(2, s_err + 1, 20, "exh_err");
    repeat (10) tick();
    check("exh_nsend", 32'(n_send - s_send), 32'd3);
    check("exh_ndone", 32'(n_done - s_done), 32'd0);
`else
    // 0xFE fails immediately
    snap();
    push(8'hF4);
    wait_for(0, s_send + 1, 20, "nores_send");
    pulse_ack();
    send_code(8'hFE);
    wait_for(2, s_err + 1, 20, "nores_err");
    repeat (10) tick();
    check("nores_nsend", 32'(n_send - s_send), 32'd1);
    check("nores_ndone", 32'(n_done - s_done), 32'd0);
    check("nores_rx_empty", 32'(rx_empty_o), 32'd1);

    // Line NACK fails immediately
    snap();
    push(8'hF6);
    wait_for(0, s_send + 1, 20, "nack_send");
    port_errd_i = 1'b1;
    tick();
    port_errd_i = 1'b0;
    wait_for(2, s_err + 1, 20, "nack_err");
    repeat (10) tick();
    check("nack_nsend", 32'(n_send - s_send), 32'd1);
`endif

    // Interleaved scan code during response wait
    snap();
    push(8'hED);
    wait_for(0, s_send + 1, 20, "intl_send");
    pulse_ack();
    send_code(8'h1C);
    check("intl_rx_nonempty", 32'(rx_empty_o), 32'd0);
    check("intl_no_done_yet", 32'(n_done - s_done), 32'd0);
    send_code(8'hFA);
    wait_for(1, s_done + 1, 20, "intl_done");
    check("intl_rx_data", 32'(rx_data_o), 32'h1C);
    pop_rx();
    check("intl_rx_single", 32'(rx_empty_o), 32'd1);

    // Response timeout, then next queued command
    snap();
    push(8'hF2);
    push(8'hEE);
    wait_for(0, s_send + 1, 20, "to_send1");
    check("to_byte1", 32'(last_cmd), 32'hF2);
    pulse_ack();
    ck1us = 1'b1;
    repeat (19990) tick();
    check("to_not_early", 32'(n_err - s_err), 32'd0);
    wait_for(2, s_err + 1, 50, "to_err");
    ck1us = 1'b0;
    wait_for(0, s_send + 2, 20, "to_send2");
    check("to_byte2", 32'(last_cmd), 32'hEE);
    pulse_ack();
    send_code(8'hFA);
    wait_for(1, s_done + 1, 20, "to_done");
    check("to_nerr", 32'(n_err - s_err), 32'd1);

    // RX overflow
    for (int i = 0; i < 9; i++) send_code(8'h10 + 8'(i));
    check("ovf_set", 32'(rx_ovf_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", 32'(rx_data_o), 32'h10 + 32'(i));
      pop_rx();
    end
    check("ovf_drained", 32'(rx_empty_o), 32'd1);
    check("ovf_sticky", 32'(rx_ovf_o), 32'd1);
    pop_rx();
    check("rd_empty_ignored", 32'(rx_empty_o), 32'd1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("ovf_cleared", 32'(rx_ovf_o), 32'd0);

    // Push and pop together on a full RX FIFO
    for (int i = 0; i < 8; i++) send_code(8'h20 + 8'(i));
    port_code_i = 8'h28;
    port_code_v_i = 1'b1;
    rx_rd_i = 1'b1;
    tick();
    port_code_v_i = 1'b0;
    rx_rd_i = 1'b0;
    check("rdwr_full_no_ovf", 32'(rx_ovf_o), 32'd0);
    check("rdwr_full_head", 32'(rx_data_o), 32'h21);
    // Overflow and clear in the same cycle: set wins
    port_code_i = 8'h29;
    port_code_v_i = 1'b1;
    ovf_clr_i = 1'b1;
    tick();
    port_code_v_i = 1'b0;
    ovf_clr_i = 1'b0;
    check("ovf_set_wins", 32'(rx_ovf_o), 32'd1);
    for (int i = 0; i < 7; i++) pop_rx();
    check("rdwr_full_tail", 32'(rx_data_o), 32'h28);
    pop_rx();
    check("rdwr_drained", 32'(rx_empty_o), 32'd1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;

    // Command FIFO full, drop, and push-with-pop while full
    snap();
    port_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    check("cmdq_full", 32'(cmd_full_o), 32'd1);
    push(8'h34);
    check("cmdq_still_full", 32'(cmd_full_o), 32'd1);
    repeat (3) tick();
    check("busy_no_send", 32'(n_send - s_send), 32'd0);
    port_busy_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_for(0, s_send + k + 1, 20, "cmdq_send");
      check("cmdq_order", 32'(last_cmd), (k < 4) ? 32'h30 + 32'(k) : 32'h35);
      pulse_ack();
      if (k == 0) begin
        cmd_i = 8'h35;
        cmd_wr_i = 1'b1;
      end
      send_code(8'hFA);
      cmd_wr_i = 1'b0;
      wait_for(1, s_done + k + 1, 20, "cmdq_done");
    end
    repeat (20) tick();
    check("cmdq_nsend", 32'(n_send - s_send), 32'd5);
    check("cmdq_empty_after", 32'(cmd_full_o), 32'd0);

    // Reset mid-command abandons it silently
    snap();
    push(8'hED);
    wait_for(0, s_send + 1, 20, "rstmid_send");
    pulse_ack();
    resetn = 1'b0;
    tick();
    check("rstmid_outs", {29'd0, port_cmd_v_o, done_o, err_o}, 32'd0);
    check("rstmid_cmd_o", 32'(port_cmd_o), 32'd0);
    tick();
    resetn = 1'b1;
    send_code(8'hFA);
    repeat (20) tick();
    check("rstmid_ndone", 32'(n_done - s_done), 32'd0);
    check("rstmid_nerr", 32'(n_err - s_err), 32'd0);
    check("rstmid_nsend", 32'(n_send - s_send), 32'd1);
    // The stray 0xFA arrived in IDLE, so it is queued as a plain byte
    check("rstmid_rx_data", 32'(rx_data_o), 32'hFA);
    pop_rx();
    check("rstmid_rx_empty", 32'(rx_empty_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctrl.md
PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 SHALL have parameter CMDQ_DEPTH, default 4, meaning command FIFO entries (power of 2).
REQ-002 SHALL have parameter RXQ_DEPTH, default 8, meaning received-byte FIFO entries (power of 2).
REQ-003 SHALL have parameter RESP_TIMEOUT_US, default 20000, meaning the limit for the TX phase and for the response wait, in microseconds.
REQ-004 SHALL have parameter MAX_RETRY, default 2, meaning the number of resends allowed after the first attempt.
REQ-005 clk6x  in  1  48MHz clock; resetn  in  1  reset, synchronous, active-low.
REQ-006 ck1us  in  1  1-cycle pulse every 1us.
REQ-007 cmd_i  in  8  command byte; cmd_wr_i  in  1  push cmd_i; cmd_full_o  out  1  command FIFO full.
REQ-008 rx_data_o  out  8  head of RX FIFO; rx_rd_i  in  1  pop; rx_empty_o  out  1  RX FIFO empty.
REQ-009 rx_ovf_o  out  1  sticky RX overflow; ovf_clr_i  in  1  clear overflow.
REQ-010 done_o  out  1  1-cycle pulse, command acknowledged with 0xFA; err_o  out  1  1-cycle pulse, command failed.
REQ-011 port_cmd_o  out  8  byte to port; port_cmd_v_o  out  1  1-cycle send strobe; port_busy_i  in  1  port busy.
REQ-012 port_acked_i  in  1  line-level ACK pulse; port_errd_i  in  1  line-level NACK pulse; port_code_i  in  8  received byte; port_code_v_i  in  1  received-byte strobe.

Function
REQ-013 States SHALL be IDLE, ISSUE, GAP, WAIT_TX, WAIT_RESP, with a 2-bit retry counter and a 15-bit microsecond timer decremented on ck1us.
REQ-014 IDLE: if the command FIFO is non-empty, go to ISSUE with retry=0; the FIFO head stays in place until the command completes.
REQ-015 ISSUE: when port_busy_i=0, drive port_cmd_v_o=1 for exactly one cycle with port_cmd_o=head, then go to GAP; otherwise stay in ISSUE.
REQ-016 GAP: spend one cycle absorbing the port's busy latency, load timer=RESP_TIMEOUT_US, then go to WAIT_TX.
REQ-017 WAIT_TX: port_acked_i reloads the timer and goes to WAIT_RESP; port_errd_i goes to the retry path; timer expiry goes to the fail path.
REQ-018 WAIT_RESP, on port_code_v_i: 0xFA pulses done_o, pops the command and goes to IDLE; 0xFE goes to the retry path; any other byte is pushed to the RX FIFO and the wait continues.
REQ-019 WAIT_RESP timer expiry goes to the fail path.
REQ-020 Retry path: if retry<MAX_RETRY, increment retry and go to ISSUE; otherwise go to the fail path.
REQ-021 Fail path: pulse err_o, pop the command, go to IDLE.
REQ-022 In IDLE, ISSUE, GAP and WAIT_TX, every port_code_v_i byte SHALL be pushed to the RX FIFO.
REQ-023 Push to a full RX FIFO: drop the byte and set rx_ovf_o.
REQ-024 Simultaneous rx_rd_i and push on a full RX FIFO: pop and push both succeed, with no overflow.
REQ-025 ovf_clr_i with a simultaneous overflow: rx_ovf_o stays 1 (set wins).
REQ-026 rx_rd_i on an empty RX FIFO: ignored.
REQ-027 cmd_wr_i while full: byte dropped, no other effect.
REQ-028 cmd_wr_i and a pop in the same cycle while full: the push SHALL be accepted.
REQ-029 FIFO pointers SHALL be log2(depth)+1 bits, wrap modulo 2*depth, with full/empty derived from the MSB difference.
REQ-030 rx_data_o SHALL be valid combinationally from the head whenever rx_empty_o=0.

Reset
REQ-031 On resetn=0, the FSM SHALL go to IDLE, and both FIFOs SHALL empty with pointers at 0.
REQ-032 On resetn=0, retry and timer SHALL be 0.
REQ-033 On resetn=0, port_cmd_o, port_cmd_v_o, done_o, err_o and rx_ovf_o SHALL be 0.
REQ-034 On resetn=0, cmd_full_o SHALL be 0 and rx_empty_o SHALL be 1.
REQ-035 Reset mid-command SHALL abandon the command with no done_o or err_o pulse.

Configuration
REQ-036 Macro PS2_HOST_RESEND_EN defined: 0xFE responses and port_errd_i take the retry path as in REQ-020.
REQ-037 Macro PS2_HOST_RESEND_EN undefined: 0xFE and port_errd_i go directly to the fail path, the retry counter is not built, and MAX_RETRY is ignored.

Verification
REQ-038 Basic command: push 0xED, device ACKs the line and then sends 0xFA -> exactly one port_cmd_v_o with 0xED, one done_o, command FIFO empty, RX FIFO empty.
REQ-039 Resend (macro on): push 0xF4, device responds 0xFE, 0xFE, 0xFA -> three port_cmd_v_o pulses with 0xF4, one done_o, no err_o.
REQ-040 Resend exhausted (macro on, MAX_RETRY=2): respond 0xFE three times -> three sends, then one err_o pulse; with the macro off -> one send, then err_o.
REQ-041 Interleaved byte: during WAIT_RESP the device sends 0x1C and then 0xFA -> RX FIFO holds exactly 0x1C, followed by done_o.
REQ-042 Timeout: line ACK, then no response for 20000 ck1us pulses -> err_o, return to IDLE, next queued command issued.
REQ-043 RX overflow: 9 scan codes with no reads -> bytes 1-8 retained in order, 9th dropped, rx_ovf_o=1 until ovf_clr_i.
